// File: rtl/sd_multi_wr_ctrl_pkg.sv
// sd_pkg: shared types and constants for the multi-sector SD write controller.
package sd_pkg;

    localparam int SD_SECTOR_WORDS = 256;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        START,
        WAIT_ACK,
        WAIT_DONE,
        NEXT,
        FINISH,
        ERR
    } sd_state_e;

endpackage

// File: rtl/sd_multi_wr_ctrl_fifo.sv
// sd_wr_fifo: single-clock DEPTH x WIDTH FIFO with registered read data, level output and
// synchronous flush. Read data updates only on a successful pop and holds otherwise.
module sd_wr_fifo #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16
) (
    input  logic                   clk_ref,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = data_q;
    assign level_o = level_q;

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        data_d   = data_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            data_d   = mem[rd_ptr_q];
        end
        if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
        else if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and level define its contents.
    always_ff @(posedge clk_ref) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/sd_multi_wr_ctrl.sv
// sd_multi_wr_ctrl: buffers user words and drives an SD write engine one 256-word sector at a time.
// Optional watchdog on the engine handshake is enabled by defining SD_WR_TIMEOUT_EN.
module sd_multi_wr_ctrl
    import sd_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 512,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        init_done,
    input  logic        start,
    input  logic [31:0] start_sec_addr,
    input  logic [15:0] sec_num,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        underrun,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    input  logic        wr_busy,
    input  logic        wr_req
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < SD_SECTOR_WORDS || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYC == 24'd0) begin : g_param_check
        $error("sd_multi_wr_ctrl: FIFO_DEPTH must be a power of two >= 256, TIMEOUT_CYC nonzero");
    end

    sd_state_e   state_q;
    logic [31:0] addr_q;
    logic [15:0] secs_q;
    logic [23:0] budget_q;
    logic        wr_start_en_q, done_q, underrun_q;
    logic [31:0] wr_sec_addr_q;
    logic        fifo_full, fifo_empty, fifo_flush, push;
    logic [LW-1:0] fifo_level;

    assign busy        = (state_q != IDLE);
    assign din_ready   = busy && !fifo_full && (budget_q != 24'd0);
    assign push        = din_valid && din_ready;
    assign done        = done_q;
    assign underrun    = underrun_q;
    assign wr_start_en = wr_start_en_q;
    assign wr_sec_addr = wr_sec_addr_q;

`ifdef SD_WR_TIMEOUT_EN
    logic [23:0] tmo_q;
    logic        err_q;
    logic        handshake_stall;
    assign err        = err_q;
    assign fifo_flush = (state_q == ERR);
    // Counter only advances while the FSM sits in one handshake state; any transition clears it.
    assign handshake_stall = (state_q == WAIT_ACK && !wr_busy) || (state_q == WAIT_DONE && wr_busy);
`else
    assign err        = 1'b0;
    assign fifo_flush = 1'b0;
`endif

    sd_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_ref (clk_ref),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (push),
        .data_i  (din),
        .pop_i   (wr_req),
        .data_o  (wr_data),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            secs_q        <= '0;
            budget_q      <= '0;
            wr_start_en_q <= 1'b0;
            wr_sec_addr_q <= '0;
            done_q        <= 1'b0;
            underrun_q    <= 1'b0;
`ifdef SD_WR_TIMEOUT_EN
            tmo_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (wr_req && fifo_empty) underrun_q <= 1'b1;
            if (push) budget_q <= budget_q - 24'd1;

            case (state_q)
                IDLE: begin
                    if (start && init_done) begin
                        underrun_q <= 1'b0;
                        if (sec_num == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q   <= start_sec_addr;
                            secs_q   <= sec_num;
                            budget_q <= {sec_num, 8'h00};
                            state_q  <= FILL;
                        end
                    end
                end
                FILL: begin
                    // A sector starts only once all of its words are already buffered.
                    if (fifo_level >= LW'(SD_SECTOR_WORDS)) begin
                        wr_start_en_q <= 1'b1;
                        wr_sec_addr_q <= addr_q;
                        state_q       <= START;
                    end
                end
                START:    state_q <= WAIT_ACK;
                WAIT_ACK: begin
                    if (wr_busy) begin
                        wr_start_en_q <= 1'b0;
                        state_q       <= WAIT_DONE;
                    end
                end
                WAIT_DONE: if (!wr_busy) state_q <= NEXT;
                NEXT: begin
                    secs_q <= secs_q - 16'd1;
                    addr_q <= addr_q + 32'd1;
                    if (secs_q != 16'd1) begin
                        state_q <= FILL;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH:  state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

`ifdef SD_WR_TIMEOUT_EN
            err_q <= 1'b0;
            tmo_q <= '0;
            if (handshake_stall) begin
                if (tmo_q + 24'd1 >= TIMEOUT_CYC) begin
                    state_q       <= ERR;
                    err_q         <= 1'b1;
                    wr_start_en_q <= 1'b0;
                    budget_q      <= '0;
                end else begin
                    tmo_q <= tmo_q + 24'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_sd_multi_wr_ctrl.sv
// Directed self-checking bench for sd_multi_wr_ctrl; the SD write engine is played by tasks.
// Build with +define+SD_WR_TIMEOUT_EN to exercise the watchdog path.
`timescale 1ns/1ps
module tb_sd_multi_wr_ctrl;

    logic        clk_ref = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_sec_addr = '0;
    logic [15:0] sec_num = '0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready, busy, done, err, underrun, wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;
    logic        wr_busy = 1'b0;
    logic        wr_req = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int sen_rise = 0;
    logic sen_prev = 1'b0;

    always #5 clk_ref = ~clk_ref;

    sd_multi_wr_ctrl #(
        .FIFO_DEPTH  (512),
        .TIMEOUT_CYC (24'd100)
    ) dut (
        .clk_ref        (clk_ref),
        .rst            (rst),
        .init_done      (init_done),
        .start          (start),
        .start_sec_addr (start_sec_addr),
        .sec_num        (sec_num),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .underrun       (underrun),
        .wr_start_en    (wr_start_en),
        .wr_sec_addr    (wr_sec_addr),
        .wr_data        (wr_data),
        .wr_busy        (wr_busy),
        .wr_req         (wr_req)
    );

    // Event monitors: pulse counts and rising edges of the engine start level.
    always @(posedge clk_ref) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (wr_start_en === 1'b1 && sen_prev !== 1'b1) sen_rise <= sen_rise + 1;
        sen_prev <= wr_start_en;
    end

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] addr, input logic [15:0] n, input logic init);
        init_done      = init;
        start_sec_addr = addr;
        sec_num        = n;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [15:0] base, input string tag);
        int   i;
        int   guard;
        logic acc;
        i = 0;
        guard = 0;
        din_valid = 1'b1;
        while (i < n && guard < 3000) begin
            din = base + i[15:0];
            acc = din_ready;
            tick();
            if (acc === 1'b1) i++;
            guard++;
        end
        din_valid = 1'b0;
        n_cmp++;
        if (i != n) begin
            $display("FAIL %s push: accepted %0d words, required %0d", tag, i, n);
            n_bad++;
        end
    endtask

    task automatic serve_sector(input logic [31:0] exp_addr, input logic [15:0] base, input string tag);
        int          guard;
        int          bad;
        int          first_idx;
        logic [15:0] first_got;
        guard = 0;
        while (wr_start_en !== 1'b1 && guard < 3000) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (wr_start_en !== 1'b1) begin
            $display("FAIL %s start_en: got %b, required 1", tag, wr_start_en);
            n_bad++;
        end
        n_cmp++;
        if (wr_sec_addr !== exp_addr) begin
            $display("FAIL %s sec_addr: got %h, required %h", tag, wr_sec_addr, exp_addr);
            n_bad++;
        end
        wr_busy = 1'b1;
        guard = 0;
        while (wr_start_en !== 1'b0 && guard < 10) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (wr_start_en !== 1'b0) begin
            $display("FAIL %s ack_clear: start_en got %b, required 0", tag, wr_start_en);
            n_bad++;
        end
        wr_req = 1'b1;
        bad = 0;
        first_idx = 0;
        first_got = '0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (wr_data !== base + k[15:0]) begin
                if (bad == 0) begin
                    first_idx = k;
                    first_got = wr_data;
                end
                bad++;
            end
        end
        wr_req = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL %s data: %0d bad words, first idx %0d got %h required %h",
                     tag, bad, first_idx, first_got, base + first_idx[15:0]);
            n_bad++;
        end
        wr_busy = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            $display("FAIL %s idle: busy got %b, required 0", tag, busy);
            n_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, err, underrun, din_ready, wr_start_en} !== 6'b0) begin
            $display("FAIL reset flags: got %b, required 000000",
                     {busy, done, err, underrun, din_ready, wr_start_en});
            n_bad++;
        end
        n_cmp++;
        if (wr_sec_addr !== 32'h0 || wr_data !== 16'h0) begin
            $display("FAIL reset data: addr %h data %h, required 0 and 0", wr_sec_addr, wr_data);
            n_bad++;
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || din_ready !== 1'b0) begin
            $display("FAIL reset idle: busy %b din_ready %b, required 0 0", busy, din_ready);
            n_bad++;
        end
    endtask

    task automatic test_zero_sectors();
        int d0, s0;
        d0 = done_cnt;
        s0 = sen_rise;
        pulse_start(32'h55, 16'd0, 1'b1);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL zero_sec pulse: done %b busy %b, required 1 0", done, busy);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            $display("FAIL zero_sec width: done got %b, required 0", done);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (done_cnt - d0 != 1 || sen_rise != s0) begin
            $display("FAIL zero_sec count: done pulses %0d start rises %0d, required 1 0",
                     done_cnt - d0, sen_rise - s0);
            n_bad++;
        end
    endtask

    task automatic test_not_init();
        int d0;
        d0 = done_cnt;
        pulse_start(32'h10, 16'd3, 1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin
            $display("FAIL not_init busy: got %b, required 0", busy);
            n_bad++;
        end
        pulse_start(32'h10, 16'd0, 1'b0);
        repeat (3) tick();
        n_cmp++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            $display("FAIL not_init done: pulses %0d busy %b, required 0 0", done_cnt - d0, busy);
            n_bad++;
        end
        init_done = 1'b1;
    endtask

    task automatic test_two_sectors();
        int d0;
        d0 = done_cnt;
        pulse_start(32'h100, 16'd2, 1'b1);
        n_cmp++;
        if (busy !== 1'b1 || din_ready !== 1'b1) begin
            $display("FAIL two_sec begin: busy %b din_ready %b, required 1 1", busy, din_ready);
            n_bad++;
        end
        push_words(512, 16'h1000, "two_sec");
        n_cmp++;
        if (din_ready !== 1'b0) begin
            $display("FAIL two_sec budget: din_ready got %b, required 0", din_ready);
            n_bad++;
        end
        pulse_start(32'h999, 16'd0, 1'b1);
        serve_sector(32'h100, 16'h1000, "two_sec_s0");
        serve_sector(32'h101, 16'h1100, "two_sec_s1");
        wait_idle("two_sec");
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            $display("FAIL two_sec done: pulses got %0d, required 1", done_cnt - d0);
            n_bad++;
        end
    endtask

    task automatic test_addr_wrap();
        int d0;
        d0 = done_cnt;
        pulse_start(32'hFFFF_FFFF, 16'd2, 1'b1);
        push_words(512, 16'h2000, "wrap");
        serve_sector(32'hFFFF_FFFF, 16'h2000, "wrap_s0");
        serve_sector(32'h0000_0000, 16'h2100, "wrap_s1");
        wait_idle("wrap");
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            $display("FAIL wrap done: pulses got %0d, required 1", done_cnt - d0);
            n_bad++;
        end
    endtask

    task automatic test_fill_gate();
        int s0, guard;
        s0 = sen_rise;
        pulse_start(32'h40, 16'd1, 1'b1);
        push_words(200, 16'h3000, "fill_a");
        repeat (20) tick();
        n_cmp++;
        if (wr_start_en !== 1'b0 || sen_rise != s0 || busy !== 1'b1 || din_ready !== 1'b1) begin
            $display("FAIL fill_hold: start_en %b rises %0d busy %b din_ready %b, required 0 0 1 1",
                     wr_start_en, sen_rise - s0, busy, din_ready);
            n_bad++;
        end
        push_words(56, 16'h30C8, "fill_b");
        guard = 0;
        while (wr_start_en !== 1'b1 && guard < 2) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (wr_start_en !== 1'b1) begin
            $display("FAIL fill_start: start_en got %b within 2 cycles, required 1", wr_start_en);
            n_bad++;
        end
        serve_sector(32'h40, 16'h3000, "fill_s0");
        wait_idle("fill");
    endtask

    task automatic test_underrun();
        n_cmp++;
        if (underrun !== 1'b0) begin
            $display("FAIL underrun pre: got %b, required 0", underrun);
            n_bad++;
        end
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        n_cmp++;
        if (underrun !== 1'b1 || wr_data !== 16'h30FF) begin
            $display("FAIL underrun set: underrun %b wr_data %h, required 1 30ff", underrun, wr_data);
            n_bad++;
        end
        repeat (3) tick();
        n_cmp++;
        if (underrun !== 1'b1) begin
            $display("FAIL underrun sticky: got %b, required 1", underrun);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        pulse_start(32'h77, 16'd1, 1'b1);
        n_cmp++;
        if (underrun !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL mid start: underrun %b busy %b, required 0 1", underrun, busy);
            n_bad++;
        end
        push_words(256, 16'h4000, "mid");
        guard = 0;
        while (wr_start_en !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        wr_busy = 1'b1;
        wr_req  = 1'b1;
        repeat (10) tick();
        wr_req  = 1'b0;
        rst     = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, err, underrun, din_ready, wr_start_en} !== 6'b0 ||
            wr_sec_addr !== 32'h0 || wr_data !== 16'h0) begin
            $display("FAIL mid reset: flags %b addr %h data %h, required 000000 0 0",
                     {busy, done, err, underrun, din_ready, wr_start_en}, wr_sec_addr, wr_data);
            n_bad++;
        end
        wr_busy = 1'b0;
        rst     = 1'b0;
        tick();
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        n_cmp++;
        if (underrun !== 1'b1 || wr_data !== 16'h0) begin
            $display("FAIL mid discard: underrun %b wr_data %h, required 1 0000", underrun, wr_data);
            n_bad++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int guard, n, e0;
        e0 = err_cnt;
        pulse_start(32'h5, 16'd1, 1'b1);
        push_words(256, 16'h5000, "tmo");
        guard = 0;
        while (wr_start_en !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
`ifdef SD_WR_TIMEOUT_EN
        n = 0;
        while (err !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        n_cmp++;
        if (err !== 1'b1 || n < 100 || n > 101) begin
            $display("FAIL tmo delay: err %b after %0d cycles, required 1 after 100..101", err, n);
            n_bad++;
        end
        n_cmp++;
        if (wr_start_en !== 1'b0) begin
            $display("FAIL tmo start_en: got %b, required 0", wr_start_en);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0 || err_cnt - e0 != 1) begin
            $display("FAIL tmo return: err %b busy %b pulses %0d, required 0 0 1",
                     err, busy, err_cnt - e0);
            n_bad++;
        end
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        n_cmp++;
        if (underrun !== 1'b1) begin
            $display("FAIL tmo flush: underrun got %b, required 1", underrun);
            n_bad++;
        end
`else
        n = 0;
        repeat (300) begin
            tick();
            n++;
        end
        n_cmp++;
        if (err_cnt != e0 || err !== 1'b0 || wr_start_en !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL no_tmo: err pulses %0d start_en %b busy %b after %0d cycles, required 0 1 1",
                     err_cnt - e0, wr_start_en, busy, n);
            n_bad++;
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_sectors();
        test_not_init();
        test_two_sectors();
        test_addr_wrap();
        test_fill_gate();
        test_underrun();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
